// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage access unit: result-select codes,
// FSM encodings, default timeout and the packed MEM/WB register payload.
// Imported by the interface, the MEM/WB register and the top.
package mem_access_unit_pkg;

   localparam int TIMEOUT_DEF = 255;

   localparam logic [1:0] RS_ALU  = 2'b00;
   localparam logic [1:0] RS_LOAD = 2'b01;
   localparam logic [1:0] RS_PC4  = 2'b10;
   localparam logic [1:0] RS_RSVD = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic        reg_write;
      logic [1:0]  result_src;
      logic [4:0]  rd;
      logic [31:0] alu_result;
      logic [31:0] read_data;
      logic [31:0] pc_plus4;
      logic        mem_err;
   } wb_t;

   // Final writeback value; the reserved select yields zero
   function automatic logic [31:0] sel_result(input wb_t w);
      logic [31:0] v;
      v = '0;
      case (w.result_src)
         RS_ALU:  v = w.alu_result;
         RS_LOAD: v = w.read_data;
         RS_PC4:  v = w.pc_plus4;
         RS_RSVD: v = '0;
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request bus between the MEM stage (master) and memory (slave).
// A request is held until dmem_ready; read data is valid with dmem_ready.
// Memory backpressures by withholding dmem_ready.
interface mem_access_unit_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register with asynchronous reset.
// Latency: one cycle from i_wb to o_wb.
// i_bubble replaces the captured value with an all-zero bubble.
module mem_wb_reg
   import mem_access_unit_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_bubble,
   input  wb_t  i_wb,
   output wb_t  o_wb
);

   wb_t r_wb;

   // Capture the next W contents, or a bubble while the MEM stage is stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wb <= '0;
      end else if (i_bubble) begin
         r_wb <= '0;
      end else begin
         r_wb <= i_wb;
      end
   end

   assign o_wb = r_wb;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory requests, waits with a bounded timeout, feeds MEM/WB.
// Latency: 1 cycle plus one per cycle dmem_ready is low; abort after TIMEOUT+1 cycles.
// Backpressure: StallM holds upstream while a request is outstanding; W gets bubbles.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      RegWriteM,
   input  logic                      MemWriteM,
   input  logic [1:0]                ResultSrcM,
   input  logic [31:0]               ALUResultM,
   input  logic [31:0]               WriteDataM,
   input  logic [31:0]               PCPlus4M,
   input  logic [4:0]                RdM,
   mem_access_unit_if.master         dmem,
   output logic                      StallM,
   output logic                      RegWriteW,
   output logic [1:0]                ResultSrcW,
   output logic [4:0]                RdW,
   output logic [31:0]               ALUResultW,
   output logic [31:0]               ReadDataW,
   output logic [31:0]               PCPlus4W,
   output logic [31:0]               ResultW,
   output logic                      MemErrW
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t     r_state;
   logic [7:0] r_cnt;

   logic w_mem_op;
   logic w_is_load;
   logic w_misalign;
   logic w_issue;
   logic w_timeout;
   logic w_done;
   logic w_abort;
   logic w_stall;
   logic w_fault;
   wb_t  w_wb_next;
   wb_t  w_wb;

   // A store with the load select set is still a store: no read data is used
   assign w_mem_op   = MemWriteM || (ResultSrcM == RS_LOAD);
   assign w_is_load  = !MemWriteM && (ResultSrcM == RS_LOAD);
   assign w_misalign = w_mem_op && (ALUResultM[1:0] != 2'b00);

   // Upstream is frozen by StallM, so IDLE and WAIT present the same request;
   // reset gating drops an outstanding request the moment reset asserts
   assign w_issue   = w_mem_op && !w_misalign && !reset;
   assign w_timeout = (r_state == ST_WAIT) && (r_cnt == TIMEOUT_CNT);
   assign w_done    = w_issue && dmem.dmem_ready;
   assign w_abort   = w_issue && !dmem.dmem_ready && w_timeout;
   assign w_stall   = w_issue && !dmem.dmem_ready && !w_timeout;
   assign w_fault   = w_misalign || w_abort;

   assign dmem.dmem_req   = w_issue;
   assign dmem.dmem_we    = w_issue && MemWriteM;
   assign dmem.dmem_addr  = ALUResultM;
   assign dmem.dmem_wdata = WriteDataM;
   assign StallM          = w_stall;

   // Faulted instructions still carry their fields but never write the RF
   always_comb begin
      w_wb_next            = '0;
      w_wb_next.reg_write  = RegWriteM && !w_fault;
      w_wb_next.result_src = ResultSrcM;
      w_wb_next.rd         = RdM;
      w_wb_next.alu_result = ALUResultM;
      w_wb_next.read_data  = (w_is_load && w_done) ? dmem.dmem_rdata : 32'h0;
      w_wb_next.pc_plus4   = PCPlus4M;
      w_wb_next.mem_err    = w_fault;
   end

   // Request FSM and wait counter; the counter holds the number of stalled cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_stall) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= 8'd1;
               end
            end
            ST_WAIT: begin
               if (w_stall) begin
                  r_cnt <= r_cnt + 8'd1;
               end else begin
                  r_state <= ST_IDLE;
                  r_cnt   <= 8'd0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 8'd0;
            end
         endcase
      end
   end

   mem_wb_reg u_mem_wb (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (w_stall),
      .i_wb     (w_wb_next),
      .o_wb     (w_wb)
   );

   assign RegWriteW  = w_wb.reg_write;
   assign ResultSrcW = w_wb.result_src;
   assign RdW        = w_wb.rd;
   assign ALUResultW = w_wb.alu_result;
   assign ReadDataW  = w_wb.read_data;
   assign PCPlus4W   = w_wb.pc_plus4;
   assign MemErrW    = w_wb.mem_err;
   assign ResultW    = sel_result(w_wb);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (TIMEOUT=4): stimulus pushes expected
// per-cycle bus/stall values and expected W contents; a negedge monitor checks.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        StallM, RegWriteW, MemErrW;
   logic [1:0]  ResultSrcW;
   logic [4:0]  RdW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ResultW;

   mem_access_unit_if dif ();

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCPlus4M   (PCPlus4M),
      .RdM        (RdM),
      .dmem       (dif),
      .StallM     (StallM),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .RdW        (RdW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .PCPlus4W   (PCPlus4W),
      .ResultW    (ResultW),
      .MemErrW    (MemErrW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        stall;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cyc_t;

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc4;
      logic        err;
      logic [31:0] res;
   } wexp_t;

   cyc_t  cq[$];
   wexp_t wq[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   logic  active   = 1'b0;
   logic  prev_act = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_c(input logic s, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
      cq.push_back({s, r, w, a, d});
   endtask

   task automatic push_w(input logic rw, input logic [1:0] rs, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic err, input logic [31:0] res);
      wq.push_back({rw, rs, rd, alu, rdata, pc4, err, res});
   endtask

   task automatic push_bubble();
      push_w(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   // Next cycle's inputs, applied 1 time unit after the rising edge
   task automatic drv(input logic act, input logic rw, input logic mw, input logic [1:0] rs,
                      input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                      input logic [4:0] rd, input logic rdy, input logic [31:0] rdata);
      @(posedge clk);
      #1;
      active         = act;
      RegWriteM      = rw;
      MemWriteM      = mw;
      ResultSrcM     = rs;
      ALUResultM     = alu;
      WriteDataM     = wd;
      PCPlus4M       = pc4;
      RdM            = rd;
      dif.dmem_ready = rdy;
      dif.dmem_rdata = rdata;
   endtask

   // Monitor: W outputs reflect the previous active cycle; bus/stall the current one
   always @(negedge clk) begin
      if (prev_act) begin
         if (wq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL w_queue_underflow: got empty expected entry");
         end else begin
            wexp_t e;
            e = wq.pop_front();
            chk("RegWriteW",  {31'h0, RegWriteW}, {31'h0, e.rw});
            chk("ResultSrcW", {30'h0, ResultSrcW}, {30'h0, e.rs});
            chk("RdW",        {27'h0, RdW}, {27'h0, e.rd});
            chk("ALUResultW", ALUResultW, e.alu);
            chk("ReadDataW",  ReadDataW, e.rdata);
            chk("PCPlus4W",   PCPlus4W, e.pc4);
            chk("MemErrW",    {31'h0, MemErrW}, {31'h0, e.err});
            chk("ResultW",    ResultW, e.res);
         end
      end
      if (active) begin
         if (cq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL c_queue_underflow: got empty expected entry");
         end else begin
            cyc_t c;
            c = cq.pop_front();
            chk("StallM",   {31'h0, StallM}, {31'h0, c.stall});
            chk("dmem_req", {31'h0, dif.dmem_req}, {31'h0, c.req});
            if (c.req) begin
               chk("dmem_we",    {31'h0, dif.dmem_we}, {31'h0, c.we});
               chk("dmem_addr",  dif.dmem_addr, c.addr);
               chk("dmem_wdata", dif.dmem_wdata, c.wdata);
            end
         end
      end
      prev_act = active;
   end

   initial begin
      reset = 1'b1;
      RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; ALUResultM = 0;
      WriteDataM = 0; PCPlus4M = 0; RdM = 0;
      dif.dmem_ready = 0; dif.dmem_rdata = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_dmem_req",  {31'h0, dif.dmem_req}, 32'h0);
      chk("rst_StallM",    {31'h0, StallM}, 32'h0);
      chk("rst_RegWriteW", {31'h0, RegWriteW}, 32'h0);
      chk("rst_ResultW",   ResultW, 32'h0);
      chk("rst_MemErrW",   {31'h0, MemErrW}, 32'h0);
      reset = 1'b0;

      // ALU op, ready asserted without a request must be ignored
      push_c(0, 0, 0, 0, 0);
      push_w(1, 2'b00, 5'd5, 32'h10, 32'h0, 32'h44, 0, 32'h10);
      drv(1, 1, 0, 2'b00, 32'h10, 32'h0, 32'h44, 5'd5, 1, 32'h12345678);

      // Load hit in the same cycle
      push_c(0, 1, 0, 32'h100, 32'h0);
      push_w(1, 2'b01, 5'd7, 32'h100, 32'hDEADBEEF, 32'h48, 0, 32'hDEADBEEF);
      drv(1, 1, 0, 2'b01, 32'h100, 32'h0, 32'h48, 5'd7, 1, 32'hDEADBEEF);

      // Store with three wait cycles
      for (int i = 0; i < 3; i++) begin
         push_c(1, 1, 1, 32'h20, 32'h55);
         push_bubble();
         drv(1, 0, 1, 2'b00, 32'h20, 32'h55, 32'h4C, 5'd0, 0, 32'hBAD0BAD0);
      end
      push_c(0, 1, 1, 32'h20, 32'h55);
      push_w(0, 2'b00, 5'd0, 32'h20, 32'h0, 32'h4C, 0, 32'h20);
      drv(1, 0, 1, 2'b00, 32'h20, 32'h55, 32'h4C, 5'd0, 1, 32'hBAD0BAD0);

      // Misaligned load: no request, faults in one cycle
      push_c(0, 0, 0, 0, 0);
      push_w(0, 2'b01, 5'd3, 32'h102, 32'h0, 32'h50, 1, 32'h0);
      drv(1, 1, 0, 2'b01, 32'h102, 32'h0, 32'h50, 5'd3, 1, 32'hFFFFFFFF);

      // Load timing out: four stalled cycles then abort
      for (int i = 0; i < 4; i++) begin
         push_c(1, 1, 0, 32'h200, 32'h0);
         push_bubble();
         drv(1, 1, 0, 2'b01, 32'h200, 32'h0, 32'h54, 5'd9, 0, 32'hAAAA5555);
      end
      push_c(0, 1, 0, 32'h200, 32'h0);
      push_w(0, 2'b01, 5'd9, 32'h200, 32'h0, 32'h54, 1, 32'h0);
      drv(1, 1, 0, 2'b01, 32'h200, 32'h0, 32'h54, 5'd9, 0, 32'hAAAA5555);

      // Back in IDLE: PC+4 select with rd=0 passed through unchanged
      push_c(0, 0, 0, 0, 0);
      push_w(1, 2'b10, 5'd0, 32'h33, 32'h0, 32'h58, 0, 32'h58);
      drv(1, 1, 0, 2'b10, 32'h33, 32'h0, 32'h58, 5'd0, 0, 32'h0);

      // Reserved select gives a zero result
      push_c(0, 0, 0, 0, 0);
      push_w(1, 2'b11, 5'd2, 32'h77, 32'h0, 32'h5C, 0, 32'h0);
      drv(1, 1, 0, 2'b11, 32'h77, 32'h0, 32'h5C, 5'd2, 0, 32'h0);

      // Store and load select both set: store, read data discarded
      push_c(0, 1, 1, 32'h40, 32'h66);
      push_w(0, 2'b01, 5'd4, 32'h40, 32'h0, 32'h60, 0, 32'h0);
      drv(1, 0, 1, 2'b01, 32'h40, 32'h66, 32'h60, 5'd4, 1, 32'hCAFEF00D);

      // Idle, let the last W entry drain
      drv(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
      drv(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);

      // Reset in the second WAIT cycle of a stalled load
      drv(0, 1, 0, 2'b01, 32'h300, 32'h0, 32'h64, 5'd8, 0, 32'h0);
      drv(0, 1, 0, 2'b01, 32'h300, 32'h0, 32'h64, 5'd8, 0, 32'h0);
      drv(0, 1, 0, 2'b01, 32'h300, 32'h0, 32'h64, 5'd8, 0, 32'h0);
      chk("pre_rst_req",   {31'h0, dif.dmem_req}, 32'h1);
      chk("pre_rst_stall", {31'h0, StallM}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_req",       {31'h0, dif.dmem_req}, 32'h0);
      chk("mid_rst_stall",     {31'h0, StallM}, 32'h0);
      chk("mid_rst_RegWriteW", {31'h0, RegWriteW}, 32'h0);
      chk("mid_rst_RdW",       {27'h0, RdW}, 32'h0);
      chk("mid_rst_ALUResW",   ALUResultW, 32'h0);
      chk("mid_rst_MemErrW",   {31'h0, MemErrW}, 32'h0);

      // Fresh ALU op right after release
      push_c(0, 0, 0, 0, 0);
      push_w(1, 2'b00, 5'd6, 32'h99, 32'h0, 32'h68, 0, 32'h99);
      drv(1, 1, 0, 2'b00, 32'h99, 32'h0, 32'h68, 5'd6, 0, 32'h0);
      reset = 1'b0;
      drv(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
      drv(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);

      chk("c_queue_drained", cq.size(), 32'h0);
      chk("w_queue_drained", wq.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
